// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: forwarding, bypass flags,
// load-use / MDU / data-memory stalls, branch flushes and perf counters.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int PERF_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_AW-1:0]     Rs1D,
  input  logic [REG_AW-1:0]     Rs2D,
  input  logic [REG_AW-1:0]     Rs1E,
  input  logic [REG_AW-1:0]     Rs2E,
  input  logic [REG_AW-1:0]     RdE,
  input  logic [REG_AW-1:0]     RdM,
  input  logic [REG_AW-1:0]     RdW,
  input  logic                  reg_writeM,
  input  logic                  reg_writeW,
  input  logic                  result_srcE0,
  input  logic                  PC_srcE,
  input  logic                  mdu_opE,
  input  logic                  mdu_done,
  input  logic                  dmem_accM,
  input  logic                  dmem_ready,
  input  logic                  perf_clr,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  for1_4A,
  output logic                  for1_4B,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  stallM,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  flushM,
  output logic                  flushW,
  output logic                  mdu_start,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } mdu_st_e;

  mdu_st_e r_state;
  mdu_st_e w_state_nxt;
  logic    r_done_seen;
  logic    w_done_seen_nxt;

  logic    w_mem_stall;
  logic    w_lw_stall;
  logic    w_mdu_stall;
  logic    w_mdu_start;
  logic    w_br_flush;
  logic    w_byp_a;
  logic    w_byp_b;

  logic    r_byp_a;
  logic    r_byp_b;
  logic [PERF_CNT_W-1:0] r_stall_cnt;
  logic [PERF_CNT_W-1:0] r_flush_cnt;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (reg_writeM && rs == RdM)
        sel = 2'b10;
      else if (reg_writeW && rs == RdW)
        sel = 2'b01;
    end
    return sel;
  endfunction

  function automatic logic [PERF_CNT_W-1:0] sat_inc(
    input logic [PERF_CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign forwardAE = fwd_sel(Rs1E);
  assign forwardBE = fwd_sel(Rs2E);

  assign w_byp_a = reg_writeW & (Rs1D == RdW) & (Rs1D != '0);
  assign w_byp_b = reg_writeW & (Rs2D == RdW) & (Rs2D != '0);

  assign w_mem_stall = dmem_accM & ~dmem_ready;

  // A memory wait state freezes everything, so the load-use check yields to it.
  assign w_lw_stall = result_srcE0 & (RdE != '0)
                    & ((Rs1D == RdE) | (Rs2D == RdE))
                    & ~w_mem_stall;

  always_comb begin
    w_state_nxt     = r_state;
    w_done_seen_nxt = r_done_seen;
    w_mdu_stall     = 1'b0;
    w_mdu_start     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_mdu_stall = mdu_opE;
        if (mdu_opE && !w_mem_stall) begin
          w_mdu_start = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_mdu_stall = 1'b1;
        if (w_mem_stall) begin
          if (mdu_done)
            w_done_seen_nxt = 1'b1;
        end else if (mdu_done || r_done_seen) begin
          w_state_nxt     = S_DONE;
          w_done_seen_nxt = 1'b0;
        end
      end
      S_DONE: begin
        if (!w_mem_stall)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_done_seen_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_done_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_seen <= w_done_seen_nxt;
    end
  end

  assign w_br_flush = PC_srcE & ~w_mem_stall & ~w_mdu_stall;

  assign stallF    = w_mem_stall | w_lw_stall | w_mdu_stall;
  assign stallD    = w_mem_stall | w_lw_stall | w_mdu_stall;
  assign stallE    = w_mem_stall | w_mdu_stall;
  assign stallM    = w_mem_stall;
  assign flushD    = w_br_flush;
  assign flushE    = w_br_flush | w_lw_stall;
  assign flushM    = w_mdu_stall & ~w_mem_stall;
  assign flushW    = w_mem_stall;
  assign mdu_start = w_mdu_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byp_a <= 1'b0;
      r_byp_b <= 1'b0;
    end else if (flushE) begin
      r_byp_a <= 1'b0;
      r_byp_b <= 1'b0;
    end else if (!stallE) begin
      r_byp_a <= w_byp_a;
      r_byp_b <= w_byp_b;
    end
  end

  assign for1_4A = r_byp_a;
  assign for1_4B = r_byp_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF)
        r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_br_flush)
        r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
